// File: rtl/tqvp_crc_checker_if.sv
// Register bus between the host/test harness and the CRC checker peripheral.
// The master drives address/write strobes; the slave returns read data and ready.
interface tqvp_crc_checker_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_crc_checker.sv
// Configurable bitwise CRC-32 checker: bytes queue in a small FIFO, are shifted
// through the CRC one bit per cycle, and the final value is compared to EXPECTED.
module tqvp_crc_checker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ui_in,
  output logic [7:0]          uo_out,
  output logic                user_interrupt,
  tqvp_crc_checker_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_CONFIG   = 6'h04;
  localparam logic [5:0] ADDR_DATA     = 6'h08;
  localparam logic [5:0] ADDR_EXPECTED = 6'h0C;
  localparam logic [5:0] ADDR_POLY     = 6'h10;
  localparam logic [5:0] ADDR_STATUS   = 6'h14;
  localparam logic [5:0] ADDR_RESULT   = 6'h18;
  localparam logic [5:0] ADDR_BYTECNT  = 6'h1C;

  localparam logic [31:0] POLY_RESET = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
    logic [31:0] rev;
    for (int i = 0; i < 32; i++) begin
      rev[i] = value[31 - i];
    end
    return rev;
  endfunction

  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic        wr_mid,
                                              input logic        wr_top);
    return {wr_top ? new_val[31:16] : old_val[31:16],
            wr_mid ? new_val[15:8]  : old_val[15:8],
            new_val[7:0]};
  endfunction

  state_t            state_r, state_next_s;
  logic [2:0]        config_r;
  logic              irq_en_r;
  logic [31:0]       expected_r, poly_r, result_r, crc_r;
  logic [15:0]       bytecount_r;
  logic              done_r, match_r, overflow_r, finish_pending_r, frame_started_r;
  logic [7:0]        byte_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  fifo_count_r;

  logic        wr_any_s, wr_mid_s, wr_top_s;
  logic        start_s, finish_s, data_wr_s, status_wr_s;
  logic        frame_active_s, fifo_empty_s, fifo_full_s;
  logic        push_s, pop_s, overflow_evt_s, busy_s, shift_bit_s;
  logic [31:0] crc_step_s, final_val_s, init_val_s;
  logic        unused_s;

  assign wr_any_s = (bus.data_write_n != 2'b11);
  assign wr_mid_s = (bus.data_write_n == 2'b01) || (bus.data_write_n == 2'b10);
  assign wr_top_s = (bus.data_write_n == 2'b10);

  assign start_s     = wr_any_s && (bus.address == ADDR_CTRL) && bus.data_in[0];
  assign finish_s    = wr_any_s && (bus.address == ADDR_CTRL) && bus.data_in[1];
  assign data_wr_s   = wr_any_s && (bus.address == ADDR_DATA);
  assign status_wr_s = wr_any_s && (bus.address == ADDR_STATUS);

  // DONE ends the frame; DATA writes after that are silently ignored.
  assign frame_active_s = frame_started_r && (state_r != ST_DONE);
  assign fifo_empty_s   = (fifo_count_r == {CNT_W{1'b0}});
  assign fifo_full_s    = (fifo_count_r == CNT_W'(FIFO_DEPTH));
  assign push_s         = data_wr_s && frame_active_s && !fifo_full_s;
  assign overflow_evt_s = data_wr_s && frame_active_s && fifo_full_s;
  assign pop_s          = (state_r == ST_LOAD);
  assign busy_s         = (state_r == ST_LOAD) || (state_r == ST_SHIFT) ||
                          (state_r == ST_FINAL) || !fifo_empty_s;

  assign shift_bit_s = config_r[0] ? byte_r[bit_cnt_r] : byte_r[3'd7 - bit_cnt_r];
  assign crc_step_s  = {crc_r[30:0], 1'b0} ^ ((crc_r[31] ^ shift_bit_s) ? poly_r : 32'h0000_0000);
  assign final_val_s = (config_r[0] ? bit_reverse32(crc_r) : crc_r) ^
                       (config_r[1] ? 32'hFFFF_FFFF : 32'h0000_0000);
  assign init_val_s  = config_r[2] ? 32'hFFFF_FFFF : 32'h0000_0000;

  assign uo_out          = {5'b00000, match_r, done_r, 1'b0};
  assign user_interrupt  = done_r & irq_en_r;
  assign bus.data_ready  = 1'b1;
  assign unused_s        = ^{ui_in, bus.data_read_n};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; START restarts from any state.
  always_comb begin
    state_next_s = state_r;
    if (start_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_next_s = ST_LOAD;
          end else if (finish_pending_r && frame_active_s) begin
            state_next_s = ST_FINAL;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD:  state_next_s = ST_SHIFT;
        ST_SHIFT: begin
          if (bit_cnt_r == 3'd7) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end
        ST_FINAL: state_next_s = ST_DONE;
        ST_DONE:  state_next_s = ST_DONE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_r   <= 1'b0;
      config_r   <= 3'b111;
      expected_r <= 32'h0000_0000;
      poly_r     <= POLY_RESET;
    end else begin
      if (wr_any_s && (bus.address == ADDR_CTRL)) begin
        irq_en_r <= bus.data_in[2];
      end
      if (wr_any_s && (bus.address == ADDR_CONFIG)) begin
        config_r <= bus.data_in[2:0];
      end
      if (wr_any_s && (bus.address == ADDR_EXPECTED)) begin
        expected_r <= merge_write(expected_r, bus.data_in, wr_mid_s, wr_top_s);
      end
      if (wr_any_s && (bus.address == ADDR_POLY)) begin
        poly_r <= merge_write(poly_r, bus.data_in, wr_mid_s, wr_top_s);
      end
    end
  end

  // Byte FIFO; a push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n || start_s) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.data_in[7:0];
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // CRC datapath, frame bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_r            <= 32'h0000_0000;
      result_r         <= 32'h0000_0000;
      bytecount_r      <= 16'h0000;
      byte_r           <= 8'h00;
      bit_cnt_r        <= 3'd0;
      done_r           <= 1'b0;
      match_r          <= 1'b0;
      overflow_r       <= 1'b0;
      finish_pending_r <= 1'b0;
      frame_started_r  <= 1'b0;
    end else if (start_s) begin
      crc_r            <= init_val_s;
      bytecount_r      <= 16'h0000;
      bit_cnt_r        <= 3'd0;
      done_r           <= 1'b0;
      match_r          <= 1'b0;
      overflow_r       <= 1'b0;
      finish_pending_r <= 1'b0;
      frame_started_r  <= 1'b1;
    end else begin
      if (overflow_evt_s) begin
        overflow_r <= 1'b1;
      end
      if (finish_s && frame_active_s) begin
        finish_pending_r <= 1'b1;
      end
      if (status_wr_s && bus.data_in[1]) begin
        done_r <= 1'b0;
      end
      case (state_r)
        ST_LOAD: begin
          byte_r    <= fifo_mem_r[rd_ptr_r];
          bit_cnt_r <= 3'd0;
          if (bytecount_r != 16'hFFFF) begin
            bytecount_r <= bytecount_r + 16'd1;
          end
        end
        ST_SHIFT: begin
          crc_r     <= crc_step_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        ST_FINAL: begin
          result_r         <= final_val_s;
          match_r          <= (final_val_s == expected_r);
          done_r           <= 1'b1;
          finish_pending_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Side-effect-free register read mux.
  always_comb begin
    bus.data_out = 32'h0000_0000;
    case (bus.address)
      ADDR_CTRL:     bus.data_out = {29'h0, irq_en_r, 2'b00};
      ADDR_CONFIG:   bus.data_out = {29'h0, config_r};
      ADDR_EXPECTED: bus.data_out = expected_r;
      ADDR_POLY:     bus.data_out = poly_r;
      ADDR_STATUS:   bus.data_out = {24'h0, 4'(fifo_count_r), overflow_r, match_r, done_r, busy_s};
      ADDR_RESULT:   bus.data_out = result_r;
      ADDR_BYTECNT:  bus.data_out = {16'h0, bytecount_r};
      default:       bus.data_out = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_tqvp_crc_checker.sv
// Directed self-checking bench for tqvp_crc_checker: reset values, write widths,
// CRC-32 and MPEG-2 check values, overflow, restart mid-byte and reset mid-frame.
module tb_tqvp_crc_checker;

  localparam logic [5:0] A_CTRL     = 6'h00;
  localparam logic [5:0] A_CONFIG   = 6'h04;
  localparam logic [5:0] A_DATA     = 6'h08;
  localparam logic [5:0] A_EXPECTED = 6'h0C;
  localparam logic [5:0] A_POLY     = 6'h10;
  localparam logic [5:0] A_STATUS   = 6'h14;
  localparam logic [5:0] A_RESULT   = 6'h18;
  localparam logic [5:0] A_BYTECNT  = 6'h1C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       user_interrupt;
  int         test_cnt = 0;
  int         fail_cnt = 0;
  logic [31:0] rd;

  tqvp_crc_checker_if bus_if ();

  tqvp_crc_checker #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .user_interrupt (user_interrupt),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    bus_if.address      = a;
    bus_if.data_in      = d;
    bus_if.data_write_n = w;
    @(negedge clk);
    bus_if.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.data_out;
  endtask

  // Polls STATUS until the selected bit equals want, bounded by a cycle budget.
  task automatic wait_status(input string tag, input int bit_idx, input logic want);
    logic [31:0] st;
    int n;
    n = 0;
    bus_read(A_STATUS, st);
    while (st[bit_idx] !== want && n < 300) begin
      @(negedge clk);
      bus_read(A_STATUS, st);
      n++;
    end
    check_eq(tag, {31'h0, st[bit_idx]}, {31'h0, want});
  endtask

  task automatic send_123456789();
    for (int i = 1; i <= 9; i++) begin
      bus_write(A_DATA, 32'h30 + i, 2'b00);
      wait_status("byte_drain", 0, 1'b0);
    end
  endtask

  task automatic run_frame(input logic [2:0] cfg, input logic [31:0] exp, input logic irq);
    bus_write(A_EXPECTED, exp, 2'b10);
    bus_write(A_CONFIG, {29'h0, cfg}, 2'b00);
    bus_write(A_CTRL, {29'h0, irq, 2'b01}, 2'b00);
    send_123456789();
    bus_write(A_CTRL, {29'h0, irq, 2'b10}, 2'b00);
    wait_status("frame_done", 1, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    bus_read(A_CTRL, rd);     check_eq({tag, "_ctrl"}, rd, 32'h0);
    bus_read(A_CONFIG, rd);   check_eq({tag, "_config"}, rd, 32'h7);
    bus_read(A_POLY, rd);     check_eq({tag, "_poly"}, rd, 32'h04C11DB7);
    bus_read(A_EXPECTED, rd); check_eq({tag, "_expected"}, rd, 32'h0);
    bus_read(A_STATUS, rd);   check_eq({tag, "_status"}, rd, 32'h0);
    bus_read(A_RESULT, rd);   check_eq({tag, "_result"}, rd, 32'h0);
    bus_read(A_BYTECNT, rd);  check_eq({tag, "_bytecnt"}, rd, 32'h0);
    check_eq({tag, "_uo_out"}, {24'h0, uo_out}, 32'h0);
    check_eq({tag, "_irq"}, {31'h0, user_interrupt}, 32'h0);
    check_eq({tag, "_ready"}, {31'h0, bus_if.data_ready}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    ui_in               = 8'h00;
    bus_if.address      = 6'h00;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = 2'b11;
    bus_if.data_read_n  = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset");

    // Write-width handling on a 32-bit register, unmapped offset reads 0.
    bus_write(A_EXPECTED, 32'hAABBCCDD, 2'b10);
    bus_write(A_EXPECTED, 32'h11223344, 2'b00);
    bus_read(A_EXPECTED, rd); check_eq("wr8", rd, 32'hAABBCC44);
    bus_write(A_EXPECTED, 32'h55667788, 2'b01);
    bus_read(A_EXPECTED, rd); check_eq("wr16", rd, 32'hAABB7788);
    bus_read(6'h20, rd);      check_eq("unmapped", rd, 32'h0);

    // Standard CRC-32 check value, matching EXPECTED.
    run_frame(3'b111, 32'hCBF43926, 1'b0);
    bus_read(A_RESULT, rd);  check_eq("crc32_result", rd, 32'hCBF43926);
    bus_read(A_STATUS, rd);  check_eq("crc32_status", rd, 32'h6);
    bus_read(A_BYTECNT, rd); check_eq("crc32_bytecnt", rd, 32'd9);
    check_eq("crc32_uo_out", {24'h0, uo_out}, 32'h06);
    check_eq("crc32_irq_off", {31'h0, user_interrupt}, 32'h0);
    bus_write(A_STATUS, 32'h2, 2'b00);
    bus_read(A_STATUS, rd);  check_eq("crc32_clr_done", rd, 32'h4);

    // Mismatch with interrupt enabled; interrupt held until done is cleared.
    run_frame(3'b111, 32'hCBF43927, 1'b1);
    bus_read(A_RESULT, rd);  check_eq("mis_result", rd, 32'hCBF43926);
    bus_read(A_STATUS, rd);  check_eq("mis_status", rd, 32'h2);
    check_eq("mis_irq", {31'h0, user_interrupt}, 32'h1);
    repeat (5) @(negedge clk);
    check_eq("mis_irq_hold", {31'h0, user_interrupt}, 32'h1);
    bus_write(A_STATUS, 32'h2, 2'b00);
    check_eq("mis_irq_clr", {31'h0, user_interrupt}, 32'h0);
    bus_read(A_STATUS, rd);  check_eq("mis_status_clr", rd, 32'h0);

    // Non-reflected, no final xor (MPEG-2 style).
    run_frame(3'b100, 32'h0, 1'b0);
    bus_read(A_RESULT, rd);  check_eq("mpeg2_result", rd, 32'h0376E6E7);
    check_eq("mpeg2_uo_out", {24'h0, uo_out}, 32'h02);

    // Empty frame: result is the init value through the output transforms.
    bus_write(A_EXPECTED, 32'hFFFFFFFF, 2'b10);
    bus_write(A_CTRL, 32'h1, 2'b00);
    bus_write(A_CTRL, 32'h2, 2'b00);
    wait_status("empty_done", 1, 1'b1);
    bus_read(A_RESULT, rd);  check_eq("empty_result", rd, 32'hFFFFFFFF);
    bus_read(A_STATUS, rd);  check_eq("empty_status", rd, 32'h6);
    bus_read(A_BYTECNT, rd); check_eq("empty_bytecnt", rd, 32'h0);

    // Six back-to-back bytes into a four-deep FIFO.
    bus_write(A_CONFIG, 32'h7, 2'b00);
    bus_write(A_CTRL, 32'h1, 2'b00);
    bus_if.address      = A_DATA;
    bus_if.data_write_n = 2'b00;
    for (int i = 0; i < 6; i++) begin
      bus_if.data_in = 32'h41 + i;
      @(negedge clk);
    end
    bus_if.data_write_n = 2'b11;
    bus_read(A_STATUS, rd);  check_eq("ovf_flag", {31'h0, rd[3]}, 32'h1);
    wait_status("ovf_drain", 0, 1'b0);
    bus_write(A_CTRL, 32'h2, 2'b00);
    wait_status("ovf_done", 1, 1'b1);
    bus_read(A_BYTECNT, rd); check_eq("ovf_bytecnt", rd, 32'd5);
    bus_read(A_STATUS, rd);  check_eq("ovf_flag_kept", {31'h0, rd[3]}, 32'h1);

    // START while a byte is being shifted restarts a clean frame.
    bus_write(A_EXPECTED, 32'hCBF43926, 2'b10);
    bus_write(A_CTRL, 32'h1, 2'b00);
    bus_write(A_DATA, 32'h55, 2'b00);
    bus_write(A_DATA, 32'hAA, 2'b00);
    bus_write(A_DATA, 32'h0F, 2'b00);
    bus_read(A_STATUS, rd);  check_eq("restart_busy", {31'h0, rd[0]}, 32'h1);
    bus_write(A_CTRL, 32'h1, 2'b00);
    bus_read(A_STATUS, rd);  check_eq("restart_status", rd, 32'h0);
    bus_read(A_BYTECNT, rd); check_eq("restart_bytecnt", rd, 32'h0);
    send_123456789();
    bus_write(A_CTRL, 32'h2, 2'b00);
    wait_status("restart_done", 1, 1'b1);
    bus_read(A_RESULT, rd);  check_eq("restart_result", rd, 32'hCBF43926);
    bus_read(A_STATUS, rd);  check_eq("restart_match", rd, 32'h6);

    // Reset in the middle of a byte aborts everything.
    bus_write(A_POLY, 32'h1EDC6F41, 2'b10);
    bus_write(A_EXPECTED, 32'h12345678, 2'b10);
    bus_write(A_CONFIG, 32'h0, 2'b00);
    bus_write(A_CTRL, 32'h5, 2'b00);
    bus_write(A_DATA, 32'h31, 2'b00);
    bus_write(A_DATA, 32'h32, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("midreset");
    repeat (40) @(negedge clk);
    check_eq("midreset_irq_late", {31'h0, user_interrupt}, 32'h0);
    bus_read(A_STATUS, rd);  check_eq("midreset_status_late", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
